apb_req_master: RTL and testbench
=================================

# apb_req_master

APB initiator that converts a simple valid/ready request/response port into APB transfers toward an APB demux/bus, so on-chip logic (DMA config engines, debug bridges) can drive the peripheral APB tree. It issues one transfer at a time with the APB SETUP/ACCESS phases. It returns read data and error status on a buffered response channel. An optional timeout terminates transfers whose slave never asserts PREADY.

## Interface
- ADDR_WIDTH, 32, width of request address and PADDR
- DATA_WIDTH, 32, width of write/read data (multiple of 8)
- TIMEOUT_CYCLES, 0, max ACCESS cycles before forced error; 0 disables the timeout
- STRB_WIDTH, DATA_WIDTH/8, derived, do not override
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  ADDR_WIDTH  transfer address
- req_write_i  in  1  1 = write, 0 = read
- req_wdata_i  in  DATA_WIDTH  write data
- req_strb_i  in  STRB_WIDTH  write byte strobes
- req_prot_i  in  3  protection attributes
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_err_o  out  1  PSLVERR or timeout
- rsp_timeout_o  out  1  response was produced by the timeout
- paddr_o, pprot_o(3), psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o  out  APB request signals
- pready_i, prdata_i(DATA_WIDTH), pslverr_i  in  APB response signals

## Operation
- FSM states are IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- req_ready_o = (IDLE) | (RESP & rsp_ready_i).
- On acceptance, register addr, write, wdata, strb and prot, then go to SETUP.
- SETUP: psel_o=1, penable_o=0. Go unconditionally to ACCESS.
- ACCESS: psel_o=1, penable_o=1. Hold while pready_i=0.
  - On pready_i=1: capture prdata_i (reads only; writes store 0) and pslverr_i, clear timeout flag, go to RESP.
- Timeout (TIMEOUT_CYCLES>0) is checked in ACCESS.
  - The counter counts ACCESS cycles without pready_i, starting at 0 on ACCESS entry.
  - If pready_i=0 in the ACCESS cycle where counter == TIMEOUT_CYCLES-1, go to RESP with rdata=0, err=1, timeout=1. psel_o/penable_o drop the next cycle.
  - pready_i=1 in that same cycle wins: normal completion.
- RESP: rsp_valid_o=1, response registers stable until the handshake.
  - Handshake with req_valid_i=1 (accepted this cycle): go to SETUP with the new request.
  - Handshake otherwise: go to IDLE.
- paddr_o, pwrite_o, pwdata_o, pstrb_o and pprot_o are driven only from registers. They are stable from SETUP through the last ACCESS cycle, and keep their last value in IDLE/RESP.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1. It saturates and never wraps.

## Timing
- Reset values:
  - psel_o, penable_o, rsp_valid_o, rsp_err_o, rsp_timeout_o = 0.
  - paddr_o, pwdata_o, pwrite_o, pstrb_o, pprot_o, rsp_rdata_o = 0.
  - req_ready_o = 1 (IDLE).
- Latency, with the request accepted at edge k:
  - SETUP in cycle k+1, ACCESS in k+2.
  - With zero-wait pready, rsp_valid_o is high in k+3.
- Throughput: back-to-back with rsp_ready_i=1 gives one transfer per 3 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from APB inputs to outputs. req_ready_o depends combinationally on rsp_ready_i.
- Reset asserted mid-transfer: psel_o/penable_o drop asynchronously and any pending response is discarded. The slave must tolerate an abandoned transfer.

## Structure
- Shared package apb_pkg holds the prot_t (3-bit) typedef and the PROT_* constants.
- The FSM state enum is local to the module.
- No sub-module is required. The timeout counter is inline.

## Test plan
- Zero-wait read: addr 0x1000_0004, prdata 0xDEADBEEF, pready high in first ACCESS. Expect psel in k+1, penable in k+2, rsp_valid in k+3 with rdata 0xDEADBEEF and err=0.
- Write with 3 wait states and pslverr=1: wdata 0xA5A5A5A5, strb 0x3. Expect paddr/pwdata/pstrb stable for all 4 ACCESS cycles, then rsp err=1 and rdata=0.
- Back-to-back: two requests with rsp_ready_i=1. Expect the second SETUP in the cycle right after the first RESP, and 3-cycle spacing between rsp_valid pulses.
- Response backpressure: rsp_ready_i=0 for 5 cycles. Expect rsp_valid held, data stable, req_ready_o=0, and no new psel.
- TIMEOUT_CYCLES=4 with pready stuck low. Expect exactly 4 ACCESS cycles, then rsp err=1, timeout=1, rdata=0. Also: pready in the 4th cycle gives a normal response with timeout=0.
- Reset pulse during ACCESS. Expect psel/penable low immediately, all outputs at reset values, and a clean new transfer after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: protection attribute type and its bit meanings.
package apb_pkg;

  typedef logic [2:0] prot_t;

  // PPROT[0] privileged, PPROT[1] non-secure, PPROT[2] instruction access
  localparam prot_t PROT_NORMAL      = 3'b000;
  localparam prot_t PROT_PRIVILEGED  = 3'b001;
  localparam prot_t PROT_NONSECURE   = 3'b010;
  localparam prot_t PROT_INSTRUCTION = 3'b100;

endpackage

// File: rtl/apb_req_master.sv
// APB initiator: turns a valid/ready request port into single APB transfers
// (SETUP then ACCESS) and returns read data / error on a buffered response
// channel. An optional timeout ends ACCESS phases the slave never completes.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i / req_ready_o     request handshake
//   req_addr_i, req_write_i,
//   req_wdata_i, req_strb_i,
//   req_prot_i                    request payload, registered on acceptance
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_rdata_o, rsp_err_o,
//   rsp_timeout_o                 response payload (rdata is 0 for writes/timeouts)
//   paddr_o .. pstrb_o, psel_o,
//   penable_o                     APB request side, all from registers/state
//   pready_i, prdata_i, pslverr_i APB response side
module apb_req_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [STRB_WIDTH-1:0] req_strb_i,
  input  logic [2:0]            req_prot_i,

  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,

  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [2:0]            pprot_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic [STRB_WIDTH-1:0] pstrb_o,
  input  logic                  pready_i,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pslverr_i
);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam int unsigned CNT_W   = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST = TO_EN ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_WIDTH-1:0] pstrb_q;
  prot_t                 pprot_q;

  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  timeout_q;

  logic [CNT_W-1:0]      cnt_q;

  logic accept;
  logic timeout_hit;

  // Ready in IDLE, or in RESP when the pending response leaves this cycle.
  assign req_ready_o = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  // Last permitted ACCESS cycle; pready_i in the same cycle still wins.
  assign timeout_hit = TO_EN && (cnt_q == CNT_W'(TO_LAST));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        psel_o  = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i || timeout_hit) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = accept ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request payload: only loaded on acceptance, so it stays stable through
  // SETUP/ACCESS and keeps its last value afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
    end else if (accept) begin
      paddr_q  <= req_addr_i;
      pwrite_q <= req_write_i;
      pwdata_q <= req_wdata_i;
      pstrb_q  <= req_strb_i;
      pprot_q  <= req_prot_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else if (state_q == ACCESS) begin
      if (pready_i) begin
        rdata_q   <= pwrite_q ? '0 : prdata_i;
        err_q     <= pslverr_i;
        timeout_q <= 1'b0;
      end else if (timeout_hit) begin
        rdata_q   <= '0;
        err_q     <= 1'b1;
        timeout_q <= 1'b1;
      end
    end
  end

  // Counts ACCESS cycles without pready_i; zeroed in SETUP, saturating.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if ((state_q == ACCESS) && !pready_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign paddr_o       = paddr_q;
  assign pwrite_o      = pwrite_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;
  assign pprot_o       = pprot_q;
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = timeout_q;

endmodule

// File: tb/tb_apb_req_master.sv
module tb_apb_req_master;
  import apb_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic [2:0]  req_prot = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;
  logic [31:0] prdata = '0;
  logic        pslverr = 1'b0;

  int checks = 0;
  int errors = 0;

  apb_req_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_write_i  (req_write),
    .req_wdata_i  (req_wdata),
    .req_strb_i   (req_strb),
    .req_prot_i   (req_prot),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .rsp_timeout_o(rsp_timeout),
    .paddr_o      (paddr),
    .pprot_o      (pprot),
    .psel_o       (psel),
    .penable_o    (penable),
    .pwrite_o     (pwrite),
    .pwdata_o     (pwdata),
    .pstrb_o      (pstrb),
    .pready_i     (pready),
    .prdata_i     (prdata),
    .pslverr_i    (pslverr)
  );

  always #5 clk = ~clk;

  // Slave behaviour per transfer: after `waits` ACCESS cycles answer with rd/err.
  typedef struct {
    int unsigned waits;
    logic [31:0] rd;
    logic        err;
  } slv_t;

  slv_t        sq[$];
  slv_t        cur;
  int unsigned acc_n = 0;

  always @(negedge clk) begin
    if (psel && !penable) begin
      if (sq.size() > 0) cur = sq.pop_front();
      else begin cur.waits = 0; cur.rd = '0; cur.err = 1'b0; end
      acc_n   = 0;
      pready  = 1'b0;
      prdata  = $urandom;
      pslverr = 1'($urandom_range(0, 1));
    end else if (psel && penable) begin
      acc_n++;
      if (acc_n - 1 == cur.waits) begin
        pready = 1'b1; prdata = cur.rd; pslverr = cur.err;
      end else begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
      end
    end else begin
      pready = 1'b0; prdata = $urandom; pslverr = 1'b0;
    end
  end

  // Expected outcome of one transfer, straight from the protocol rules.
  typedef struct packed {
    int unsigned n_access;
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  function automatic exp_t model(input logic w, input int unsigned waits,
                                 input logic [31:0] srd, input logic serr);
    exp_t e;
    if (waits >= TO) begin
      e.n_access = TO; e.rdata = '0; e.err = 1'b1; e.to = 1'b1;
    end else begin
      e.n_access = waits + 1; e.rdata = w ? 32'h0 : srd; e.err = serr; e.to = 1'b0;
    end
    return e;
  endfunction

  typedef struct {
    logic        acc_ready;
    int          setup_t;
    int          n_access;
    int          rsp_t;
    int          fields_bad;
    int          hold_bad;
    logic [31:0] rdata;
    logic        err;
    logic        to;
    logic        ready_at_resp;
    logic        valid_after;
  } obs_t;

  // Drives one request from IDLE and records what the DUT did; t=0 is the
  // cycle right after the accepting edge.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr, input int unsigned waits,
                      input logic [31:0] srd, input logic serr, input int unsigned hold,
                      output obs_t o);
    slv_t s;
    s.waits = waits; s.rd = srd; s.err = serr;
    sq.push_back(s);
    o.setup_t = -1; o.rsp_t = -1; o.n_access = 0; o.fields_bad = 0; o.hold_bad = 0;
    o.rdata = 'x; o.err = 1'bx; o.to = 1'bx; o.ready_at_resp = 1'bx; o.valid_after = 1'bx;
    rsp_ready = (hold == 0);
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = wd; req_strb = st; req_prot = pr;
    #1;
    o.acc_ready = req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_write = 1'($urandom_range(0, 1));
    req_wdata = $urandom; req_strb = 4'($urandom); req_prot = 3'($urandom);
    for (int t = 0; t < 40; t++) begin
      if (psel) begin
        if (paddr !== a || pwrite !== w || pwdata !== wd || pstrb !== st || pprot !== pr)
          o.fields_bad++;
        if (!penable && o.setup_t < 0) o.setup_t = t;
        if (penable) o.n_access++;
      end
      if (rsp_valid) begin
        o.rsp_t = t; o.rdata = rsp_rdata; o.err = rsp_err; o.to = rsp_timeout;
        break;
      end
      @(posedge clk); #1;
    end
    if (o.rsp_t >= 0) begin
      for (int unsigned h = 0; h < hold; h++) begin
        if (!rsp_valid || rsp_rdata !== o.rdata || rsp_err !== o.err ||
            rsp_timeout !== o.to || req_ready || psel)
          o.hold_bad++;
        @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      #1;
      o.ready_at_resp = req_ready;
      @(posedge clk); #1;
      o.valid_after = rsp_valid | psel;
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (psel !== 1'b0) begin errors++; $display("FAIL rst_psel: got %b exp 0", psel); end
    checks++; if (penable !== 1'b0) begin errors++; $display("FAIL rst_penable: got %b exp 0", penable); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b exp 0", rsp_err); end
    checks++; if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL rst_rsp_timeout: got %b exp 0", rsp_timeout); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h exp 0", rsp_rdata); end
    checks++; if (paddr !== 32'h0) begin errors++; $display("FAIL rst_paddr: got %h exp 0", paddr); end
    checks++; if (pwdata !== 32'h0) begin errors++; $display("FAIL rst_pwdata: got %h exp 0", pwdata); end
    checks++; if (pwrite !== 1'b0) begin errors++; $display("FAIL rst_pwrite: got %b exp 0", pwrite); end
    checks++; if (pstrb !== 4'h0) begin errors++; $display("FAIL rst_pstrb: got %h exp 0", pstrb); end
    checks++; if (pprot !== 3'h0) begin errors++; $display("FAIL rst_pprot: got %h exp 0", pprot); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b exp 1", req_ready); end
  endtask

  task automatic test_zero_wait_read();
    obs_t o;
    exp_t e;
    e = model(1'b0, 0, 32'hDEADBEEF, 1'b0);
    xfer(32'h1000_0004, 1'b0, 32'h0, 4'hF, PROT_NORMAL, 0, 32'hDEADBEEF, 1'b0, 0, o);
    checks++; if (o.acc_ready !== 1'b1) begin errors++; $display("FAIL zw_accept: got %b exp 1", o.acc_ready); end
    checks++; if (o.setup_t != 0) begin errors++; $display("FAIL zw_setup_t: got %0d exp 0", o.setup_t); end
    checks++; if (o.n_access != int'(e.n_access)) begin errors++; $display("FAIL zw_n_access: got %0d exp %0d", o.n_access, e.n_access); end
    checks++; if (o.rsp_t != int'(e.n_access) + 1) begin errors++; $display("FAIL zw_rsp_t: got %0d exp %0d", o.rsp_t, e.n_access + 1); end
    checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL zw_rdata: got %h exp %h", o.rdata, e.rdata); end
    checks++; if (o.err !== e.err) begin errors++; $display("FAIL zw_err: got %b exp %b", o.err, e.err); end
    checks++; if (o.fields_bad != 0) begin errors++; $display("FAIL zw_fields: got %0d bad cycles exp 0", o.fields_bad); end
    checks++; if (o.ready_at_resp !== 1'b1) begin errors++; $display("FAIL zw_ready_in_resp: got %b exp 1", o.ready_at_resp); end
    checks++; if (o.valid_after !== 1'b0) begin errors++; $display("FAIL zw_idle_after: got %b exp 0", o.valid_after); end
  endtask

  task automatic test_write_wait_err();
    obs_t o;
    exp_t e;
    e = model(1'b1, 3, 32'h7777_7777, 1'b1);
    xfer(32'h2000_0010, 1'b1, 32'hA5A5A5A5, 4'h3, PROT_PRIVILEGED, 3, 32'h7777_7777, 1'b1, 0, o);
    checks++; if (o.n_access != int'(e.n_access)) begin errors++; $display("FAIL wr_n_access: got %0d exp %0d", o.n_access, e.n_access); end
    checks++; if (o.fields_bad != 0) begin errors++; $display("FAIL wr_fields_stable: got %0d bad cycles exp 0", o.fields_bad); end
    checks++; if (o.rsp_t != int'(e.n_access) + 1) begin errors++; $display("FAIL wr_rsp_t: got %0d exp %0d", o.rsp_t, e.n_access + 1); end
    checks++; if (o.err !== e.err) begin errors++; $display("FAIL wr_err: got %b exp %b", o.err, e.err); end
    checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL wr_rdata: got %h exp %h", o.rdata, e.rdata); end
    checks++; if (o.to !== e.to) begin errors++; $display("FAIL wr_timeout: got %b exp %b", o.to, e.to); end
  endtask

  task automatic test_backpressure();
    obs_t o;
    exp_t e;
    e = model(1'b0, 1, 32'hCAFE_F00D, 1'b0);
    xfer(32'h0000_0100, 1'b0, 32'h0, 4'hF, PROT_NONSECURE, 1, 32'hCAFE_F00D, 1'b0, 5, o);
    checks++; if (o.hold_bad != 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles exp 0", o.hold_bad); end
    checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL bp_rdata: got %h exp %h", o.rdata, e.rdata); end
    checks++; if (o.valid_after !== 1'b0) begin errors++; $display("FAIL bp_release: got %b exp 0", o.valid_after); end
  endtask

  task automatic test_timeout();
    obs_t o;
    exp_t e;
    e = model(1'b0, 50, 32'h5555_5555, 1'b0);
    xfer(32'h0000_0200, 1'b0, 32'h0, 4'hF, PROT_NORMAL, 50, 32'h5555_5555, 1'b0, 0, o);
    checks++; if (o.n_access != int'(e.n_access)) begin errors++; $display("FAIL to_n_access: got %0d exp %0d", o.n_access, e.n_access); end
    checks++; if (o.err !== 1'b1 || o.to !== 1'b1) begin errors++; $display("FAIL to_flags: got err=%b to=%b exp err=1 to=1", o.err, o.to); end
    checks++; if (o.rdata !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h exp 0", o.rdata); end
    e = model(1'b0, TO - 1, 32'h1234_5678, 1'b0);
    xfer(32'h0000_0204, 1'b0, 32'h0, 4'hF, PROT_NORMAL, TO - 1, 32'h1234_5678, 1'b0, 0, o);
    checks++; if (o.n_access != int'(e.n_access)) begin errors++; $display("FAIL to_edge_n_access: got %0d exp %0d", o.n_access, e.n_access); end
    checks++; if (o.to !== 1'b0 || o.err !== 1'b0) begin errors++; $display("FAIL to_edge_flags: got err=%b to=%b exp err=0 to=0", o.err, o.to); end
    checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL to_edge_rdata: got %h exp %h", o.rdata, e.rdata); end
  endtask

  task automatic test_back_to_back();
    int          su[$];
    int          rv[$];
    logic [31:0] rd[$];
    logic [31:0] pa[$];
    slv_t        s;
    s.waits = 0; s.err = 1'b0;
    s.rd = 32'h1111_2222; sq.push_back(s);
    s.rd = 32'h3333_4444; sq.push_back(s);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0000_A000; req_write = 1'b0;
    req_wdata = '0; req_strb = 4'hF; req_prot = PROT_NORMAL;
    @(posedge clk); #1;
    req_addr = 32'h0000_B000;
    for (int t = 0; t < 16; t++) begin
      if (psel && !penable) begin
        su.push_back(t); pa.push_back(paddr);
        if (su.size() == 2) req_valid = 1'b0;
      end
      if (rsp_valid) begin rv.push_back(t); rd.push_back(rsp_rdata); end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    checks++;
    if (su.size() != 2 || rv.size() != 2) begin
      errors++; $display("FAIL b2b_counts: got setups=%0d rsps=%0d exp 2 2", su.size(), rv.size());
    end else begin
      checks++; if (su[1] != 3) begin errors++; $display("FAIL b2b_second_setup: got t=%0d exp t=3", su[1]); end
      checks++; if (rv[0] != 2 || rv[1] != 5) begin errors++; $display("FAIL b2b_rsp_t: got %0d,%0d exp 2,5", rv[0], rv[1]); end
      checks++; if (rd[0] !== 32'h1111_2222 || rd[1] !== 32'h3333_4444) begin errors++; $display("FAIL b2b_rdata: got %h,%h exp 11112222,33334444", rd[0], rd[1]); end
      checks++; if (pa[0] !== 32'h0000_A000 || pa[1] !== 32'h0000_B000) begin errors++; $display("FAIL b2b_paddr: got %h,%h exp 0000a000,0000b000", pa[0], pa[1]); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    slv_t s;
    s.waits = 50; s.rd = '0; s.err = 1'b0;
    sq.push_back(s);
    req_valid = 1'b1; req_addr = 32'hFFFF_0000; req_write = 1'b1;
    req_wdata = 32'h0BAD_0BAD; req_strb = 4'hA; req_prot = PROT_INSTRUCTION;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (penable !== 1'b1) begin errors++; $display("FAIL rm_in_access: got %b exp 1", penable); end
    #2; rst_n = 1'b0; #1;
    checks++; if (psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL rm_async_drop: got psel=%b penable=%b exp 0 0", psel, penable); end
    checks++; if (paddr !== 32'h0 || pwdata !== 32'h0 || pstrb !== 4'h0 || pprot !== 3'h0 || pwrite !== 1'b0) begin
      errors++; $display("FAIL rm_apb_regs: got %h %h %h %h %b exp all 0", paddr, pwdata, pstrb, pprot, pwrite);
    end
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rm_handshake: got rsp_valid=%b req_ready=%b exp 0 1", rsp_valid, req_ready); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(32'h0000_0300, 1'b0, 32'h0, 4'hF, PROT_NORMAL, 0, 32'hFEED_BEEF, 1'b0, 0, o);
    checks++; if (o.rsp_t != 2 || o.rdata !== 32'hFEED_BEEF || o.err !== 1'b0) begin
      errors++; $display("FAIL rm_after: got t=%0d rdata=%h err=%b exp t=2 feedbeef 0", o.rsp_t, o.rdata, o.err);
    end
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    logic [31:0] a, wd, srd;
    logic        w, serr;
    logic [3:0]  st;
    logic [2:0]  pr;
    int unsigned waits, hold;
    for (int i = 0; i < 20; i++) begin
      a = $urandom; wd = $urandom; srd = $urandom; w = 1'($urandom_range(0, 1));
      serr = 1'($urandom_range(0, 1)); st = 4'($urandom); pr = 3'($urandom);
      waits = $urandom_range(0, 6); hold = $urandom_range(0, 3);
      e = model(w, waits, srd, serr);
      xfer(a, w, wd, st, pr, waits, srd, serr, hold, o);
      checks++; if (o.setup_t != 0) begin errors++; $display("FAIL rnd%0d_setup_t: got %0d exp 0", i, o.setup_t); end
      checks++; if (o.n_access != int'(e.n_access)) begin errors++; $display("FAIL rnd%0d_n_access: got %0d exp %0d", i, o.n_access, e.n_access); end
      checks++; if (o.rsp_t != int'(e.n_access) + 1) begin errors++; $display("FAIL rnd%0d_rsp_t: got %0d exp %0d", i, o.rsp_t, e.n_access + 1); end
      checks++; if (o.rdata !== e.rdata || o.err !== e.err || o.to !== e.to) begin
        errors++; $display("FAIL rnd%0d_rsp: got %h/%b/%b exp %h/%b/%b", i, o.rdata, o.err, o.to, e.rdata, e.err, e.to);
      end
      checks++; if (o.fields_bad != 0 || o.hold_bad != 0) begin
        errors++; $display("FAIL rnd%0d_stable: got fields_bad=%0d hold_bad=%0d exp 0 0", i, o.fields_bad, o.hold_bad);
      end
      checks++; if (o.valid_after !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle_after: got %b exp 0", i, o.valid_after); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_zero_wait_read();
    test_write_wait_err();
    test_back_to_back();
    @(posedge clk); #1;
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
